// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types for the slave-side arbiter.
// Transfer/burst encodings, arbiter states and burst length helper.
package ahb_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_type;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_BURST,
    ARB_LOCK
  } arb_state_type;

  // Remaining beats after the NONSEQ of a fixed burst (len-1).
  function automatic logic [3:0] burst_len(hburst_type b);
    logic [3:0] len;
    case (b)
      WRAP4, INCR4:   len = 4'd3;
      WRAP8, INCR8:   len = 4'd7;
      WRAP16, INCR16: len = 4'd15;
      default:        len = 4'd0;
    endcase
    return len;
  endfunction

  function automatic logic burst_fixed(hburst_type b);
    return !(b == SINGLE || b == INCR);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Circular priority encoder for round-robin arbitration.
// Scans req starting one past ptr and reports the first hit.
module ahb_rr_picker #(
  parameter int M     = 3,
  parameter int IDX_W = 2
) (
  input  logic [M-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  // First requester after ptr, wrapping around; ptr itself scanned last.
  always_comb begin
    int j;
    logic [IDX_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    j      = 0;
    idx    = '0;
    for (int i = 1; i <= M; i++) begin
      j   = (int'(ptr) + i) % M;
      idx = IDX_W'(j);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave round-robin arbiter with burst and lock ownership.
// Drives registered address/data phase master selects.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int SLAVE_X_MASTER_NUM = 3,
  parameter int IDX_W =
    ($clog2(SLAVE_X_MASTER_NUM) > 1) ?
    $clog2(SLAVE_X_MASTER_NUM) : 1
) (
  input  logic                          hclk,
  input  logic                          hreset_n,
  input  logic [SLAVE_X_MASTER_NUM-1:0] hreq,
  input  htrans_type                    htrans [SLAVE_X_MASTER_NUM],
  input  hburst_type                    hburst [SLAVE_X_MASTER_NUM],
  input  logic [SLAVE_X_MASTER_NUM-1:0] hmastlock,
  input  logic                          hready,
  output logic [SLAVE_X_MASTER_NUM-1:0] hgrant,
  output logic [IDX_W-1:0]              addr_master,
  output logic                          addr_valid,
  output logic [IDX_W-1:0]              data_master,
  output logic                          data_valid
);

  localparam int M = SLAVE_X_MASTER_NUM;

  arb_state_type    state;
  arb_state_type    nxt_state;
  arb_state_type    o_state;
  logic [3:0]       beat_cnt;
  logic [3:0]       nxt_cnt;
  logic [3:0]       o_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic [M-1:0]     win_oh;
  logic             found;
  logic             take_arb;
  logic             o_arb;
  logic             own_req;
  logic             own_lock;
  logic             own_live;
  logic             own_ns;
  htrans_type       own_trans;
  hburst_type       own_burst;

  ahb_rr_picker #(
    .M     (M),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (hreq),
    .ptr    (rr_ptr),
    .winner (win),
    .found  (found)
  );

  // Current owner's request and address-phase controls.
  always_comb begin
    own_req   = hreq[addr_master];
    own_lock  = hmastlock[addr_master];
    own_trans = htrans[addr_master];
    own_burst = hburst[addr_master];
    own_live  = addr_valid && own_req && own_trans != IDLE;
    own_ns    = own_live && own_trans == NONSEQ;
  end

  // One-hot form of the picker winner.
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < M; i++) begin
      win_oh[i] = (IDX_W'(i) == win);
    end
  end

  // Ownership rules for a plain owned phase (reused by burst/lock exits).
  always_comb begin
    o_arb   = 1'b0;
    o_state = ARB_OWNED;
    o_cnt   = beat_cnt;
    unique case (1'b1)
      !own_live:
        o_arb = 1'b1;
      own_ns && own_lock:
        o_state = ARB_LOCK;
      own_ns && !own_lock && burst_fixed(own_burst): begin
        o_state = ARB_BURST;
        o_cnt   = burst_len(own_burst);
      end
      own_ns && !own_lock && !burst_fixed(own_burst):
        o_arb = 1'b1;
      default: ;
    endcase
  end

  // Next state / counter and whether this edge is an arbitration point.
  always_comb begin
    take_arb  = 1'b0;
    nxt_state = state;
    nxt_cnt   = beat_cnt;
    unique case (state)
      ARB_IDLE:
        take_arb = 1'b1;
      ARB_OWNED: begin
        take_arb  = o_arb;
        nxt_state = o_state;
        nxt_cnt   = o_cnt;
      end
      ARB_BURST: begin
        if (own_live && own_trans == SEQ) begin
          if (beat_cnt <= 4'd1) take_arb = 1'b1;
          else nxt_cnt = beat_cnt - 4'd1;
        end else if (!(own_live && own_trans == BUSY)) begin
          take_arb  = o_arb;
          nxt_state = o_state;
          nxt_cnt   = o_cnt;
        end
      end
      ARB_LOCK: begin
        if (!own_lock) begin
          take_arb  = o_arb;
          nxt_state = o_state;
          nxt_cnt   = o_cnt;
        end
      end
      default:
        take_arb = 1'b1;
    endcase
    if (take_arb) begin
      nxt_state = found ? ARB_OWNED : ARB_IDLE;
      nxt_cnt   = 4'd0;
    end
  end

  // Arbiter FSM, grant and data-phase registers; frozen while hready=0.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= ARB_IDLE;
      beat_cnt    <= 4'd0;
      rr_ptr      <= IDX_W'(M - 1);
      hgrant      <= '0;
      addr_master <= '0;
      addr_valid  <= 1'b0;
      data_master <= '0;
      data_valid  <= 1'b0;
    end else if (hready) begin
      data_master <= addr_master;
      data_valid  <= addr_valid && own_req &&
                     (own_trans == NONSEQ || own_trans == SEQ);
      state       <= nxt_state;
      beat_cnt    <= nxt_cnt;
      if (take_arb) begin
        if (found) begin
          hgrant      <= win_oh;
          addr_master <= win;
          addr_valid  <= 1'b1;
          rr_ptr      <= win;
        end else begin
          hgrant     <= '0;
          addr_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with three masters.
// Vector table plus hand sequences for reset cases.
module tb_ahb_slave_arbiter;
  import ahb_slave_arbiter_pkg::*;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] B = 2'd1;
  localparam logic [1:0] N = 2'd2;
  localparam logic [1:0] S = 2'd3;
  localparam logic [2:0] SG  = 3'd0;
  localparam logic [2:0] I4  = 3'd3;
  localparam logic [2:0] I8  = 3'd5;
  localparam logic [2:0] W16 = 3'd6;

  typedef struct {
    logic [2:0] req;
    logic [5:0] tr;
    logic [8:0] bu;
    logic [2:0] lk;
    logic       rdy;
    logic [2:0] eg;
    logic       edv;
    logic [1:0] edm;
  } vec_t;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [2:0] hreq;
  htrans_type htrans [3];
  hburst_type hburst [3];
  logic [2:0] hmastlock;
  logic       hready;
  logic [2:0] hgrant;
  logic [1:0] addr_master;
  logic       addr_valid;
  logic [1:0] data_master;
  logic       data_valid;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 hclk = ~hclk;

  ahb_slave_arbiter #(
    .SLAVE_X_MASTER_NUM (3)
  ) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .hreq        (hreq),
    .htrans      (htrans),
    .hburst      (hburst),
    .hmastlock   (hmastlock),
    .hready      (hready),
    .hgrant      (hgrant),
    .addr_master (addr_master),
    .addr_valid  (addr_valid),
    .data_master (data_master),
    .data_valid  (data_valid)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [2:0] req, logic [5:0] tr,
                              logic [8:0] bu, logic [2:0] lk,
                              logic rdy, logic [2:0] eg,
                              logic edv, logic [1:0] edm);
    vec_t v;
    v.req = req; v.tr = tr; v.bu = bu; v.lk = lk;
    v.rdy = rdy; v.eg = eg; v.edv = edv; v.edm = edm;
    return v;
  endfunction

  function automatic logic [1:0] oh_idx(logic [2:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 3; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic drive(vec_t v);
    hreq      = v.req;
    hmastlock = v.lk;
    hready    = v.rdy;
    for (int i = 0; i < 3; i++) begin
      htrans[i] = htrans_type'(v.tr[2*i +: 2]);
      hburst[i] = hburst_type'(v.bu[3*i +: 3]);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_vec(string tag, vec_t v);
    chk({tag, " hgrant"}, 32'(hgrant), 32'(v.eg));
    chk({tag, " addr_valid"}, 32'(addr_valid), 32'(|v.eg));
    if (|v.eg)
      chk({tag, " addr_master"}, 32'(addr_master),
          32'(oh_idx(v.eg)));
    chk({tag, " data_valid"}, 32'(data_valid), 32'(v.edv));
    chk({tag, " data_master"}, 32'(data_master), 32'(v.edm));
  endtask

  initial begin
    vec_t v;
    // round robin over three SINGLE requesters
    vecs.push_back(mk(3'b111, {N,N,N}, 9'd0, 3'b000, 1, 3'b001, 0, 2'd0));
    vecs.push_back(mk(3'b111, {N,N,N}, 9'd0, 3'b000, 1, 3'b010, 1, 2'd0));
    vecs.push_back(mk(3'b111, {N,N,N}, 9'd0, 3'b000, 1, 3'b100, 1, 2'd1));
    vecs.push_back(mk(3'b111, {N,N,N}, 9'd0, 3'b000, 1, 3'b001, 1, 2'd2));
    vecs.push_back(mk(3'b000, {I,I,I}, 9'd0, 3'b000, 1, 3'b000, 0, 2'd0));
    // master1 INCR4, master0 joins in beat 2
    vecs.push_back(mk(3'b010, {I,N,I}, {SG,I4,SG}, 3'b000, 1, 3'b010, 0, 2'd0));
    vecs.push_back(mk(3'b010, {I,N,I}, {SG,I4,SG}, 3'b000, 1, 3'b010, 1, 2'd1));
    vecs.push_back(mk(3'b011, {I,S,N}, {SG,I4,SG}, 3'b000, 1, 3'b010, 1, 2'd1));
    vecs.push_back(mk(3'b011, {I,S,N}, {SG,I4,SG}, 3'b000, 1, 3'b010, 1, 2'd1));
    vecs.push_back(mk(3'b011, {I,S,N}, {SG,I4,SG}, 3'b000, 1, 3'b001, 1, 2'd1));
    vecs.push_back(mk(3'b001, {I,I,N}, 9'd0, 3'b000, 1, 3'b001, 1, 2'd0));
    vecs.push_back(mk(3'b000, {I,I,I}, 9'd0, 3'b000, 1, 3'b000, 0, 2'd0));
    // same burst with one BUSY
    vecs.push_back(mk(3'b010, {I,N,I}, {SG,I4,SG}, 3'b000, 1, 3'b010, 0, 2'd0));
    vecs.push_back(mk(3'b010, {I,N,I}, {SG,I4,SG}, 3'b000, 1, 3'b010, 1, 2'd1));
    vecs.push_back(mk(3'b011, {I,S,N}, {SG,I4,SG}, 3'b000, 1, 3'b010, 1, 2'd1));
    vecs.push_back(mk(3'b011, {I,B,N}, {SG,I4,SG}, 3'b000, 1, 3'b010, 0, 2'd1));
    vecs.push_back(mk(3'b011, {I,S,N}, {SG,I4,SG}, 3'b000, 1, 3'b010, 1, 2'd1));
    vecs.push_back(mk(3'b011, {I,S,N}, {SG,I4,SG}, 3'b000, 1, 3'b001, 1, 2'd1));
    vecs.push_back(mk(3'b000, {I,I,I}, 9'd0, 3'b000, 1, 3'b000, 0, 2'd0));
    // master2 locked over three SINGLEs
    vecs.push_back(mk(3'b101, {N,I,N}, 9'd0, 3'b100, 1, 3'b100, 0, 2'd0));
    vecs.push_back(mk(3'b101, {N,I,N}, 9'd0, 3'b100, 1, 3'b100, 1, 2'd2));
    vecs.push_back(mk(3'b101, {N,I,N}, 9'd0, 3'b100, 1, 3'b100, 1, 2'd2));
    vecs.push_back(mk(3'b101, {N,I,N}, 9'd0, 3'b100, 1, 3'b100, 1, 2'd2));
    vecs.push_back(mk(3'b101, {N,I,N}, 9'd0, 3'b000, 1, 3'b001, 1, 2'd2));
    vecs.push_back(mk(3'b000, {I,I,I}, 9'd0, 3'b000, 1, 3'b000, 0, 2'd0));
    // master2 INCR8 with a 3-cycle hready=0 stall
    vecs.push_back(mk(3'b100, {N,I,I}, {I8,SG,SG}, 3'b000, 1, 3'b100, 0, 2'd0));
    vecs.push_back(mk(3'b100, {N,I,I}, {I8,SG,SG}, 3'b000, 1, 3'b100, 1, 2'd2));
    vecs.push_back(mk(3'b100, {S,I,I}, {I8,SG,SG}, 3'b000, 1, 3'b100, 1, 2'd2));
    vecs.push_back(mk(3'b100, {S,I,I}, {I8,SG,SG}, 3'b000, 1, 3'b100, 1, 2'd2));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(3'b011, {I,N,N}, 9'd0, 3'b000, 0, 3'b100, 1, 2'd2));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(3'b111, {S,N,N}, {I8,SG,SG}, 3'b000, 1, 3'b100, 1, 2'd2));
    vecs.push_back(mk(3'b111, {S,N,N}, {I8,SG,SG}, 3'b000, 1, 3'b001, 1, 2'd2));
    vecs.push_back(mk(3'b000, {I,I,I}, 9'd0, 3'b000, 1, 3'b000, 0, 2'd0));

    hreset_n = 1'b0;
    drive(mk(3'b000, {I,I,I}, 9'd0, 3'b000, 1, 3'b000, 0, 2'd0));
    repeat (2) @(posedge hclk);
    #1;
    chk("rst hgrant", 32'(hgrant), 32'd0);
    chk("rst addr_valid", 32'(addr_valid), 32'd0);
    chk("rst addr_master", 32'(addr_master), 32'd0);
    chk("rst data_valid", 32'(data_valid), 32'd0);
    chk("rst data_master", 32'(data_master), 32'd0);
    @(negedge hclk);
    hreset_n = 1'b1;

    // no requests after release
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle hgrant", 32'(hgrant), 32'd0);
      chk("idle addr_valid", 32'(addr_valid), 32'd0);
      chk("idle data_valid", 32'(data_valid), 32'd0);
    end

    foreach (vecs[k]) begin
      drive(vecs[k]);
      step();
      chk_vec($sformatf("vec%0d", k), vecs[k]);
    end

    // master1 WRAP16, async reset in beat 5
    v = mk(3'b010, {I,N,I}, {SG,W16,SG}, 3'b000, 1, 3'b010, 0, 2'd0);
    drive(v);
    step();
    chk("w16 grant", 32'(hgrant), 32'b010);
    step();
    chk("w16 nonseq", 32'(hgrant), 32'b010);
    v.tr = {I,S,I};
    drive(v);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("w16 seq", 32'(hgrant), 32'b010);
    end
    chk("w16 data_master", 32'(data_master), 32'd1);
    #3 hreset_n = 1'b0;
    #1;
    chk("arst hgrant", 32'(hgrant), 32'd0);
    chk("arst addr_valid", 32'(addr_valid), 32'd0);
    chk("arst addr_master", 32'(addr_master), 32'd0);
    chk("arst data_valid", 32'(data_valid), 32'd0);
    chk("arst data_master", 32'(data_master), 32'd0);
    #2 hreset_n = 1'b1;
    drive(mk(3'b111, {N,N,N}, 9'd0, 3'b000, 1, 3'b000, 0, 2'd0));
    step();
    chk("post rst hgrant", 32'(hgrant), 32'b001);
    chk("post rst addr_master", 32'(addr_master), 32'd0);
    chk("post rst data_valid", 32'(data_valid), 32'd0);
    step();
    chk("post rst rr", 32'(hgrant), 32'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
